stage_mem: RTL

STAGE_MEM -- requirements
Module: stage_mem

---
 rtl/stage_mem_pkg.sv | 21 ++
 rtl/mem_timeout_cnt.sv | 37 +++
 rtl/stage_mem.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/stage_mem_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM states, ex_ctrl
// bit positions and sticky error flag positions.
package stage_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  // ex_ctrl = {MemRead, MemWrite, Branch, RegWrite, MemtoReg}
  localparam int unsigned CtrlMemRead  = 4;
  localparam int unsigned CtrlMemWrite = 3;
  localparam int unsigned CtrlBranch   = 2;
  localparam int unsigned CtrlRegWrite = 1;
  localparam int unsigned CtrlMemtoReg = 0;

  localparam int unsigned ErrMisalign = 0;
  localparam int unsigned ErrTimeout  = 1;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Wait-cycle counter for a data-memory access; tc flags the last permitted
// cycle so the owner can abandon the access at the end of it.
module mem_timeout_cnt #(
  parameter int unsigned Limit = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = (Limit > 1) ? $clog2(Limit) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  // The cycle with count Limit-1 is the Limit-th cycle without an ack.
  assign tc = (cnt_q == W'(Limit - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stage_mem.sv
// MEM pipeline stage: captures one EX result, performs an optional data-memory
// access with timeout, resolves branches, and emits a single writeback pulse.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu,
  input  logic        ex_zero,
  input  logic [31:0] ex_branch_addr,
  input  logic [31:0] ex_rt,
  input  logic [4:0]  ex_wreg,
  input  logic [4:0]  ex_ctrl,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_wreg,
  output logic        wb_regwrite,
  output logic [1:0]  err
);

  state_e      state_q, state_d;
  logic [31:0] alu_q, alu_d, baddr_q, baddr_d, rt_q, rt_d, rdata_q, rdata_d;
  logic [4:0]  ctrl_q, ctrl_d, wreg_q, wreg_d;
  logic        zero_q, zero_d, first_q, first_d, suppress_q, suppress_d;
  logic [1:0]  err_q, err_d;
  logic        tc, is_mem, misalign, in_access, in_done;

  assign is_mem    = ex_ctrl[CtrlMemRead] | ex_ctrl[CtrlMemWrite];
  assign misalign  = (ex_alu[1:0] != 2'b00);
  assign in_access = (state_q == StAccess);
  assign in_done   = (state_q == StDone);

  mem_timeout_cnt #(
    .Limit(MEM_TIMEOUT)
  ) u_timeout (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  ((state_q == StIdle) && ex_valid),
    .en   (in_access && !mem_ack),
    .tc   (tc)
  );

  always_comb begin
    state_d    = state_q;
    alu_d      = alu_q;
    baddr_d    = baddr_q;
    rt_d       = rt_q;
    rdata_d    = rdata_q;
    ctrl_d     = ctrl_q;
    wreg_d     = wreg_q;
    zero_d     = zero_q;
    suppress_d = suppress_q;
    err_d      = err_q;
    first_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ex_valid) begin
          alu_d      = ex_alu;
          baddr_d    = ex_branch_addr;
          rt_d       = ex_rt;
          ctrl_d     = ex_ctrl;
          wreg_d     = ex_wreg;
          zero_d     = ex_zero;
          rdata_d    = '0;
          first_d    = 1'b1;
          suppress_d = is_mem && misalign;
          if (is_mem && misalign) begin
            err_d[ErrMisalign] = 1'b1;
            state_d            = StDone;
          end else if (is_mem) begin
            state_d = StAccess;
          end else begin
            state_d = StDone;
          end
        end
      end
      StAccess: begin
        // An ack in the terminal cycle still completes normally.
        if (mem_ack) begin
          rdata_d = mem_rdata;
          state_d = StDone;
        end else if (tc) begin
          err_d[ErrTimeout] = 1'b1;
          suppress_d        = 1'b1;
          state_d           = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall         = (state_q != StIdle);
    pc_src        = first_q && ctrl_q[CtrlBranch] && zero_q;
    branch_target = pc_src ? baddr_q : '0;
    mem_req       = in_access;
    mem_we        = in_access && ctrl_q[CtrlMemWrite];
    mem_addr      = in_access ? alu_q : '0;
    mem_wdata     = in_access ? rt_q : '0;
    wb_valid      = in_done;
    wb_wreg       = in_done ? wreg_q : '0;
    wb_data       = !in_done ? '0 : (ctrl_q[CtrlMemtoReg] ? rdata_q : alu_q);
    wb_regwrite   = in_done && ctrl_q[CtrlRegWrite] && !suppress_q;
    err           = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      alu_q      <= '0;
      baddr_q    <= '0;
      rt_q       <= '0;
      rdata_q    <= '0;
      ctrl_q     <= '0;
      wreg_q     <= '0;
      zero_q     <= 1'b0;
      first_q    <= 1'b0;
      suppress_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      alu_q      <= alu_d;
      baddr_q    <= baddr_d;
      rt_q       <= rt_d;
      rdata_q    <= rdata_d;
      ctrl_q     <= ctrl_d;
      wreg_q     <= wreg_d;
      zero_q     <= zero_d;
      first_q    <= first_d;
      suppress_q <= suppress_d;
      err_q      <= err_d;
    end
  end

endmodule
